// File: rtl/pp_pkg.sv
// Shared widths and types for the pp scheduler and its datapath connection.
package pp_pkg;
  localparam int NUM_SIZE      = 16;
  localparam int CMD_SIZE_LOG2 = 3;
  localparam int CMD_W         = 2 ** CMD_SIZE_LOG2;
  // Tag id field is wide enough for up to 16 requesters.
  localparam int ID_W          = 4;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/pp_ifc.sv
// Scheduler <-> pp datapath connection; issue valid stays on the scheduler side.
interface pp_ifc;
  import pp_pkg::*;
  logic [CMD_W-1:0]    cmd;
  logic [NUM_SIZE-1:0] in1;
  logic [NUM_SIZE-1:0] in2;
  logic                out;
  logic [NUM_SIZE-1:0] out1;

  modport dut   (input  cmd, in1, in2, output out, out1);
  modport sched (output cmd, in1, in2, input  out, out1);
endinterface

// File: rtl/pp_rr_pick.sv
// Round-robin pick: first set req bit at or after ptr, wrapping; one-hot grant.
module pp_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  localparam logic [PW:0] LIM = (PW+1)'(N);

  logic [PW:0] pos;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= LIM) pos = pos - LIM;
      if (!found && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pp_sched.sv
// Shares one fixed-latency pp datapath among NUM_REQ requesters with
// round-robin arbitration, burst locking with a stall timeout, and in-order responses.
module pp_sched import pp_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int PP_LATENCY   = 2,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ-1:0][CMD_W-1:0]    req_cmd,
  input  logic [NUM_REQ-1:0][NUM_SIZE-1:0] req_in1,
  input  logic [NUM_REQ-1:0][NUM_SIZE-1:0] req_in2,
  output logic                             pp_valid,
  output logic [CMD_W-1:0]                 pp_cmd,
  output logic [NUM_SIZE-1:0]              pp_in1,
  output logic [NUM_SIZE-1:0]              pp_in2,
  input  logic                             pp_out,
  input  logic [NUM_SIZE-1:0]              pp_out1,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic                             rsp_out,
  output logic [NUM_SIZE-1:0]              rsp_out1,
  output logic                             lock_err,
  output logic [31:0]                      ops_issued
);
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int STALL_W = $clog2(LOCK_TIMEOUT + 1);

  sched_state_e        state;
  logic [PTR_W-1:0]    rr_ptr, owner, acc_id;
  logic [STALL_W-1:0]  stall_cnt;
  logic [NUM_REQ-1:0]  rr_grant;
  logic                accept, acc_last;
  logic [CMD_W-1:0]    acc_cmd;
  logic [NUM_SIZE-1:0] acc_in1, acc_in2;
  // Stage 0 is the issue stage (drives pp_valid); stage PP_LATENCY is tag exit.
  tag_t                tag_pipe [PP_LATENCY:0];
  tag_t                tag_exit;

  pp_ifc dp ();

  assign pp_cmd   = dp.cmd;
  assign pp_in1   = dp.in1;
  assign pp_in2   = dp.in2;
  assign dp.out   = pp_out;
  assign dp.out1  = pp_out1;
  assign pp_valid = tag_pipe[0].valid;
  assign tag_exit = tag_pipe[PP_LATENCY];

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == PTR_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  pp_rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  always_comb begin
    req_ready = '0;
    if (reset) begin
      if (state == ST_OPEN) req_ready = rr_grant;
      else                  req_ready[owner] = req_valid[owner];
    end
  end

  // req_ready is only ever set where req_valid is, so any ready bit is an acceptance.
  assign accept = |req_ready;

  always_comb begin
    acc_id   = '0;
    acc_last = 1'b0;
    acc_cmd  = '0;
    acc_in1  = '0;
    acc_in2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        acc_id   = PTR_W'(i);
        acc_last = req_last[i];
        acc_cmd  = req_cmd[i];
        acc_in1  = req_in1[i];
        acc_in2  = req_in2[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_OPEN;
      rr_ptr     <= '0;
      owner      <= '0;
      stall_cnt  <= '0;
      dp.cmd     <= '0;
      dp.in1     <= '0;
      dp.in2     <= '0;
      rsp_valid  <= '0;
      rsp_out    <= 1'b0;
      rsp_out1   <= '0;
      lock_err   <= 1'b0;
      ops_issued <= '0;
      for (int k = 0; k <= PP_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: accept, id: ID_W'(acc_id)};
      for (int k = 1; k <= PP_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];

      if (accept) begin
        dp.cmd <= acc_cmd;
        dp.in1 <= acc_in1;
        dp.in2 <= acc_in2;
        if (ops_issued != '1) ops_issued <= ops_issued + 32'd1;
      end

      for (int i = 0; i < NUM_REQ; i++)
        rsp_valid[i] <= tag_exit.valid && (tag_exit.id == ID_W'(i));
      if (tag_exit.valid) begin
        rsp_out  <= dp.out;
        rsp_out1 <= dp.out1;
      end

      case (state)
        ST_OPEN: begin
          if (accept) begin
            rr_ptr    <= wrap_inc(acc_id);
            stall_cnt <= '0;
            if (!acc_last) begin
              state <= ST_LOCKED;
              owner <= acc_id;
            end
          end
        end
        default: begin
          if (accept) begin
            stall_cnt <= '0;
            if (acc_last) state <= ST_OPEN;
          end else if (stall_cnt == STALL_W'(LOCK_TIMEOUT - 1)) begin
            state     <= ST_OPEN;
            lock_err  <= 1'b1;
            rr_ptr    <= wrap_inc(owner);
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pp_sched.sv
// Directed + randomized bench for pp_sched against a cycle-level behavioural model.
module tb_pp_sched;
  import pp_pkg::*;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]               req_valid, req_ready, req_last, rsp_valid;
  logic [N-1:0][CMD_W-1:0]    req_cmd;
  logic [N-1:0][NUM_SIZE-1:0] req_in1, req_in2;
  logic                       pp_valid, pp_out, rsp_out, lock_err;
  logic [CMD_W-1:0]           pp_cmd;
  logic [NUM_SIZE-1:0]        pp_in1, pp_in2, pp_out1, rsp_out1;
  logic [31:0]                ops_issued;

  always #5 clk = ~clk;

  pp_sched #(.NUM_REQ(N), .PP_LATENCY(L), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_cmd(req_cmd), .req_in1(req_in1), .req_in2(req_in2),
    .pp_valid(pp_valid), .pp_cmd(pp_cmd), .pp_in1(pp_in1), .pp_in2(pp_in2),
    .pp_out(pp_out), .pp_out1(pp_out1),
    .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_out1(rsp_out1),
    .lock_err(lock_err), .ops_issued(ops_issued)
  );

  // Stand-in datapath: fixed L-cycle pipeline of an arbitrary function.
  function automatic logic [NUM_SIZE-1:0] dp_f1(logic [CMD_W-1:0] c, logic [NUM_SIZE-1:0] a, logic [NUM_SIZE-1:0] b);
    return (a + b) ^ NUM_SIZE'(c);
  endfunction
  function automatic logic dp_f0(logic [NUM_SIZE-1:0] a, logic [NUM_SIZE-1:0] b);
    return a < b;
  endfunction

  logic [NUM_SIZE-1:0] dq1 [L];
  logic                dq0 [L];
  always @(posedge clk) begin
    dq1[0] <= dp_f1(pp_cmd, pp_in1, pp_in2);
    dq0[0] <= dp_f0(pp_in1, pp_in2);
    for (int k = 1; k < L; k++) begin
      dq1[k] <= dq1[k-1];
      dq0[k] <= dq0[k-1];
    end
  end
  assign pp_out1 = dq1[L-1];
  assign pp_out  = dq0[L-1];

  int passes = 0, fails = 0, checks = 0, cyc = 0;

  typedef struct {
    int                  due;
    int                  id;
    logic                o;
    logic [NUM_SIZE-1:0] o1;
  } rsp_t;
  rsp_t rq[$];

  bit                  m_locked, m_err, m_ppv;
  int                  m_ptr, m_owner, m_stall;
  longint unsigned     m_ops;
  logic [CMD_W-1:0]    m_cmd;
  logic [NUM_SIZE-1:0] m_in1, m_in2;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int m_pick();
    if (!reset) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_ppv = 0;
    m_ptr = 0; m_owner = 0; m_stall = 0; m_ops = 0;
    m_cmd = '0; m_in1 = '0; m_in2 = '0;
    rq.delete();
  endtask

  task automatic model_accept(int g);
    m_ppv = (g >= 0);
    if (g >= 0) begin
      m_cmd = req_cmd[g];
      m_in1 = req_in1[g];
      m_in2 = req_in2[g];
      if (m_ops != 64'hFFFF_FFFF) m_ops++;
      rq.push_back('{due: cyc + L + 1, id: g, o: dp_f0(m_in1, m_in2), o1: dp_f1(m_cmd, m_in1, m_in2)});
      if (!m_locked) begin
        m_ptr = (g + 1) % N;
        if (!req_last[g]) begin m_locked = 1; m_owner = g; end
      end else if (req_last[g]) begin
        m_locked = 0;
      end
      m_stall = 0;
    end else if (m_locked) begin
      m_stall++;
      if (m_stall == TO) begin
        m_locked = 0; m_err = 1; m_ptr = (m_owner + 1) % N; m_stall = 0;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = m_pick();
    exp_rdy = (g < 0) ? '0 : (N'(1) << g);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else        model_accept(g);
    @(negedge clk);
    chk("pp_valid", 64'(pp_valid), 64'(m_ppv));
    chk("pp_cmd", 64'(pp_cmd), 64'(m_cmd));
    chk("pp_in1", 64'(pp_in1), 64'(m_in1));
    chk("pp_in2", 64'(pp_in2), 64'(m_in2));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << rq[0].id));
      chk("rsp_out", 64'(rsp_out), 64'(rq[0].o));
      chk("rsp_out1", 64'(rsp_out1), 64'(rq[0].o1));
      void'(rq.pop_front());
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'(0));
    end
    chk("lock_err", 64'(lock_err), 64'(m_err));
    chk("ops_issued", 64'(ops_issued), m_ops);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_cmd[i] = CMD_W'($urandom);
      req_in1[i] = NUM_SIZE'($urandom);
      req_in2[i] = NUM_SIZE'($urandom);
    end
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (L + 3) tick();
  endtask

  initial begin
    req_valid = '0; req_last = '0; req_cmd = '0; req_in1 = '0; req_in2 = '0;
    model_reset();
    @(negedge clk);
    tick(); tick();
    chk("rst_pp_valid", 64'(pp_valid), 64'(0));
    chk("rst_rsp_out1", 64'(rsp_out1), 64'(0));
    chk("rst_ops", 64'(ops_issued), 64'(0));
    reset = 1'b1;

    // All requesters streaming single ops: plain rotation.
    req_valid = '1; req_last = '1;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      #1 chk("rr_rotation", 64'(req_ready), 64'(N'(1) << (k % N)));
      tick();
    end
    chk("ops_after_5", 64'(ops_issued), 64'(5));
    drain();

    // Single op from requester 1 with known operands.
    req_valid = 4'b0010;
    req_cmd[1] = 8'h03; req_in1[1] = 16'd5; req_in2[1] = 16'd7;
    tick();
    chk("op1_issue", 64'({pp_valid, pp_cmd, pp_in1, pp_in2}), 64'({1'b1, 8'h03, 16'd5, 16'd7}));
    req_valid = '0;
    repeat (L) tick();
    chk("op1_rsp_early", 64'(rsp_valid), 64'(0));
    tick();
    chk("op1_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("op1_rsp_out1", 64'(rsp_out1), 64'(16'h000F));
    drain();

    // Burst from requester 2 holds off requester 0.
    req_valid = 4'b0101; req_last = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      req_last[2] = (k == 2);
      #1 chk("burst_hold_r0", 64'(req_ready[0]), 64'(0));
      tick();
    end
    req_valid = 4'b0001;
    #1 chk("burst_then_r0", 64'(req_ready), 64'(4'b0001));
    tick();
    drain();

    // Requester 3 locks then goes idle until the timeout.
    req_valid = 4'b1000; req_last = 4'b0111;
    tick();
    req_valid = 4'b0001; req_last = '1;
    repeat (TO - 1) tick();
    chk("lock_err_before_to", 64'(lock_err), 64'(0));
    tick();
    chk("lock_err_at_to", 64'(lock_err), 64'(1));
    #1 chk("grant_after_to", 64'(req_ready), 64'(4'b0001));
    tick();
    drain();

    // Reset with two ops in flight discards them.
    req_valid = 4'b0011;
    rand_data(); tick();
    rand_data(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; req_valid = '0;
    chk("midrst_outputs", 64'({pp_valid, rsp_valid, lock_err, rsp_out, pp_cmd}), 64'(0));
    chk("midrst_ops", 64'(ops_issued), 64'(0));
    repeat (L + 3) begin
      tick();
      chk("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(3) != 0);
      rand_data();
      reset = ($urandom_range(99) != 0);
      tick();
    end
    reset = 1'b0; req_valid = '0;
    tick();
    reset = 1'b1;

    // Saturation of the issue counter.
    force dut.ops_issued = 32'hFFFF_FFFE;
    #1 release dut.ops_issued;
    m_ops = 64'hFFFF_FFFE;
    req_valid = 4'b0001; req_last = '1;
    rand_data(); tick();
    rand_data(); tick();
    chk("ops_saturate", 64'(ops_issued), 64'hFFFF_FFFF);
    rand_data(); tick();
    chk("ops_hold_max", 64'(ops_issued), 64'hFFFF_FFFF);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
